mcs4_bus_tracer: RTL and testbench

//   Parametrised MCS-4 bus observer/decoder for multi-chip systems (up to 16 ROMs, 4 RAM banks).

---
 rtl/mcs4_bus_tracer.sv | 210 +++++++++++++++++++++
 tb/tb_mcs4_bus_tracer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_bus_tracer.sv
// Passive MCS-4 bus observer: tracks the A1..X3 subcycles from clk2/SYNC and decodes
// instruction fetches, ROM chip select, SRC and I/O events, and keeps a trace FIFO of fetches.
module mcs4_bus_tracer #(
  parameter int NUM_ROMS     = 16,
  parameter int NUM_RAM_BANK = 4,
  parameter int TRACE_DEPTH  = 16
) (
  input  logic                    sysclk,
  input  logic                    poc,
  input  logic                    clk1_pad,
  input  logic                    clk2_pad,
  input  logic                    sync_pad,
  input  logic                    cmrom_pad,
  input  logic [NUM_RAM_BANK-1:0] cmram_pad,
  input  logic [3:0]              data_pad,
  output logic [2:0]              phase,
  output logic                    in_sync,
  output logic                    resync_err,
  output logic [NUM_ROMS-1:0]     rom_sel,
  output logic                    instr_valid,
  output logic [11:0]             fetch_addr,
  output logic [3:0]              opr,
  output logic [3:0]              opa,
  output logic                    src_valid,
  output logic [2:0]              src_bank,
  output logic [7:0]              src_addr,
  output logic                    io_valid,
  output logic [2:0]              io_bank,
  input  logic                    trc_rd,
  output logic                    trc_valid,
  output logic [19:0]             trc_data,
  output logic                    trc_ovf
);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3} phase_e;

  function automatic logic [2:0] bank_code(input logic [NUM_RAM_BANK-1:0] ram, input logic rom);
    logic [2:0] code;
    code = rom ? 3'd4 : 3'd0;
    for (int i = NUM_RAM_BANK - 1; i >= 0; i--)
      if (ram[i]) code = 3'(i);
    return code;
  endfunction

  function automatic logic [NUM_ROMS-1:0] rom_onehot(input logic [3:0] chip);
    logic [NUM_ROMS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_ROMS; i++)
      if (int'(chip) == i) oh[i] = 1'b1;
    return oh;
  endfunction

  // clk1 carries no extra timing information; the clk2 falling edge paces every subcycle
  logic w_unused_clk1;
  assign w_unused_clk1 = clk1_pad;

  logic   r_clk2_d;
  phase_e r_phase, w_phase_nxt;
  logic   r_in_sync, w_in_sync_nxt;
  logic   w_tick, w_any_cm, w_err, w_cap;

  assign w_tick   = r_clk2_d & ~clk2_pad;
  assign w_any_cm = cmrom_pad | (|cmram_pad);
  assign w_err    = w_tick & r_in_sync & sync_pad & (r_phase != PH_X3);
  assign w_cap    = w_tick & r_in_sync & ~w_err;

  always_comb begin
    w_phase_nxt   = r_phase;
    w_in_sync_nxt = r_in_sync;
    if (w_tick) begin
      if (sync_pad) begin
        w_phase_nxt   = PH_A1;
        w_in_sync_nxt = 1'b1;
      end else if (r_in_sync) begin
        w_phase_nxt = phase_e'(3'(r_phase + 3'd1));
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (poc) begin
      r_clk2_d  <= 1'b0;
      r_phase   <= PH_A1;
      r_in_sync <= 1'b0;
    end else begin
      r_clk2_d  <= clk2_pad;
      r_phase   <= w_phase_nxt;
      r_in_sync <= w_in_sync_nxt;
    end
  end

  // Shadow capture: nibbles collect here and only reach the outputs once the cycle completes
  logic [11:0]         r_sh_addr;
  logic [3:0]          r_sh_opr, r_sh_x2;
  logic [NUM_ROMS-1:0] r_sh_rom;
  logic [2:0]          r_sh_src_bank;

  always_ff @(posedge sysclk) begin
    if (w_cap) begin
      case (r_phase)
        PH_A1: r_sh_addr[3:0] <= data_pad;
        PH_A2: r_sh_addr[7:4] <= data_pad;
        PH_A3: begin
          r_sh_addr[11:8] <= data_pad;
          r_sh_rom        <= cmrom_pad ? rom_onehot(data_pad) : '0;
        end
        PH_M1: r_sh_opr <= data_pad;
        PH_X2: begin
          r_sh_x2       <= data_pad;
          r_sh_src_bank <= bank_code(cmram_pad, cmrom_pad);
        end
        default: ;
      endcase
    end
  end

  logic                r_instr_valid, r_io_valid, r_src_valid, r_src_pend, r_resync_err;
  logic [11:0]         r_fetch_addr;
  logic [3:0]          r_opr, r_opa;
  logic [NUM_ROMS-1:0] r_rom_sel;
  logic [2:0]          r_io_bank, r_src_bank;
  logic [7:0]          r_src_addr;
  logic                w_m2_cap, w_x3_src;

  assign w_m2_cap = w_cap & (r_phase == PH_M2);
  assign w_x3_src = w_cap & (r_phase == PH_X3) & r_src_pend;

  always_ff @(posedge sysclk) begin
    if (poc) begin
      r_instr_valid <= 1'b0;
      r_io_valid    <= 1'b0;
      r_src_valid   <= 1'b0;
      r_src_pend    <= 1'b0;
      r_resync_err  <= 1'b0;
      r_fetch_addr  <= '0;
      r_opr         <= '0;
      r_opa         <= '0;
      r_rom_sel     <= '0;
      r_io_bank     <= '0;
      r_src_bank    <= '0;
      r_src_addr    <= '0;
    end else begin
      r_instr_valid <= w_m2_cap;
      r_io_valid    <= w_m2_cap & w_any_cm;
      r_src_valid   <= w_x3_src;
      if (w_err) r_resync_err <= 1'b1;
      if (w_tick) r_src_pend <= w_cap & (r_phase == PH_X2) & w_any_cm;
      if (w_m2_cap) begin
        r_fetch_addr <= r_sh_addr;
        r_opr        <= r_sh_opr;
        r_opa        <= data_pad;
        r_rom_sel    <= r_sh_rom;
        if (w_any_cm) r_io_bank <= bank_code(cmram_pad, cmrom_pad);
      end
      if (w_x3_src) begin
        r_src_bank <= r_sh_src_bank;
        r_src_addr <= {r_sh_x2, data_pad};
      end
    end
  end

  // Trace FIFO: a pop frees the head slot in the same cycle, so a full FIFO still accepts a push then
  logic [19:0]   r_mem [TRACE_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_push, w_pop, w_full, w_wr;

  assign w_push = r_instr_valid;
  assign w_pop  = trc_rd & (r_count != '0);
  assign w_full = (r_count == CW'(TRACE_DEPTH));
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge sysclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_fetch_addr, r_opr, r_opa};
  end

  always_ff @(posedge sysclk) begin
    if (poc) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
    end
  end

  assign phase       = r_phase;
  assign in_sync     = r_in_sync;
  assign resync_err  = r_resync_err;
  assign rom_sel     = r_rom_sel;
  assign instr_valid = r_instr_valid;
  assign fetch_addr  = r_fetch_addr;
  assign opr         = r_opr;
  assign opa         = r_opa;
  assign src_valid   = r_src_valid;
  assign src_bank    = r_src_bank;
  assign src_addr    = r_src_addr;
  assign io_valid    = r_io_valid;
  assign io_bank     = r_io_bank;
  assign trc_valid   = (r_count != '0);
  assign trc_data    = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign trc_ovf     = r_ovf;
endmodule

// File: tb/tb_mcs4_bus_tracer.sv
// Bench for mcs4_bus_tracer: directed MCS-4 instruction cycles, an event/queue model of the
// expected decode results and trace FIFO, and literal spot checks of known answers.
`timescale 1ns/1ps
module tb_mcs4_bus_tracer;
  localparam int NR = 4;
  localparam int NB = 4;
  localparam int TD = 16;

  logic          sysclk = 1'b0;
  logic          poc, clk1_pad, clk2_pad, sync_pad, cmrom_pad, trc_rd;
  logic [NB-1:0] cmram_pad;
  logic [3:0]    data_pad;
  logic [2:0]    phase;
  logic          in_sync, resync_err, instr_valid, src_valid, io_valid, trc_valid, trc_ovf;
  logic [NR-1:0] rom_sel;
  logic [11:0]   fetch_addr;
  logic [3:0]    opr, opa;
  logic [2:0]    src_bank, io_bank;
  logic [7:0]    src_addr;
  logic [19:0]   trc_data;

  mcs4_bus_tracer #(.NUM_ROMS(NR), .NUM_RAM_BANK(NB), .TRACE_DEPTH(TD)) dut (
    .sysclk(sysclk), .poc(poc), .clk1_pad(clk1_pad), .clk2_pad(clk2_pad), .sync_pad(sync_pad),
    .cmrom_pad(cmrom_pad), .cmram_pad(cmram_pad), .data_pad(data_pad), .phase(phase),
    .in_sync(in_sync), .resync_err(resync_err), .rom_sel(rom_sel), .instr_valid(instr_valid),
    .fetch_addr(fetch_addr), .opr(opr), .opa(opa), .src_valid(src_valid), .src_bank(src_bank),
    .src_addr(src_addr), .io_valid(io_valid), .io_bank(io_bank), .trc_rd(trc_rd),
    .trc_valid(trc_valid), .trc_data(trc_data), .trc_ovf(trc_ovf)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [11:0]   addr;
    logic [3:0]    opr;
    logic [3:0]    opa;
    logic [NR-1:0] rom;
  } instr_t;
  typedef struct packed {
    logic [2:0] bank;
    logic [7:0] addr;
  } src_t;

  instr_t      q_instr[$];
  src_t        q_src[$];
  logic [2:0]  q_io[$];
  logic [19:0] m_fifo[$];
  instr_t      m_cur;
  src_t        m_src;
  logic [2:0]  m_io;
  logic        m_resync, m_ovf, m_push;
  logic [19:0] m_push_val;

  // Lowest RAM bank wins; CM-ROM alone reads as bank 4
  function automatic logic [2:0] exp_bank(input logic [NB-1:0] ram, input logic rom);
    for (int i = 0; i < NB; i++)
      if (ram[i]) return 3'(i);
    return rom ? 3'd4 : 3'd0;
  endfunction

  function automatic logic [NR-1:0] exp_rom(input logic cm, input logic [3:0] chip);
    logic [NR-1:0] one;
    one = '0;
    one[0] = 1'b1;
    if (!cm || int'(chip) >= NR) return '0;
    return one << chip;
  endfunction

  function automatic logic [19:0] entry(input int i);
    logic [3:0] n;
    n = i[3:0];
    return {12'h100 + i[11:0], n, ~n};
  endfunction

  // One subcycle: clk1 pulse, clk2 pulse, tick on clk2 fall; then phase/lock check
  task automatic sub(input logic [3:0] d, input logic s, input logic crom,
                     input logic [NB-1:0] cram, input logic [2:0] exp_ph);
    @(negedge sysclk);
    data_pad = d; sync_pad = s; cmrom_pad = crom; cmram_pad = cram; clk1_pad = 1'b1;
    @(negedge sysclk); clk1_pad = 1'b0;
    @(negedge sysclk); clk2_pad = 1'b1;
    @(negedge sysclk); clk2_pad = 1'b0;
    @(posedge sysclk); #1;
    chk("phase", phase, exp_ph);
    chk("in_sync", in_sync, 1);
  endtask

  task automatic cyc(input logic [11:0] a, input logic [3:0] o1, input logic [3:0] o2,
                     input logic rcm, input logic [NB-1:0] m2ram, input logic m2rom,
                     input logic [NB-1:0] x2ram, input logic x2rom,
                     input logic [3:0] x2, input logic [3:0] x3);
    instr_t e;
    src_t   s;
    e.addr = a; e.opr = o1; e.opa = o2; e.rom = exp_rom(rcm, a[11:8]);
    q_instr.push_back(e);
    if (m2rom || m2ram != '0) q_io.push_back(exp_bank(m2ram, m2rom));
    if (x2rom || x2ram != '0) begin
      s.bank = exp_bank(x2ram, x2rom);
      s.addr = {x2, x3};
      q_src.push_back(s);
    end
    sub(a[3:0],  1'b0, 1'b0,  '0,    3'd1);
    sub(a[7:4],  1'b0, 1'b0,  '0,    3'd2);
    sub(a[11:8], 1'b0, rcm,   '0,    3'd3);
    sub(o1,      1'b0, 1'b0,  '0,    3'd4);
    sub(o2,      1'b0, m2rom, m2ram, 3'd5);
    sub(4'h0,    1'b0, 1'b0,  '0,    3'd6);
    sub(x2,      1'b0, x2rom, x2ram, 3'd7);
    sub(x3,      1'b1, 1'b0,  '0,    3'd0);
  endtask

  task automatic fetch(input logic [19:0] ent);
    cyc(ent[19:8], ent[7:4], ent[3:0], 1'b1, '0, 1'b0, '0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic lock();
    sub(4'h0, 1'b1, 1'b0, '0, 3'd0);
  endtask

  task automatic do_reset();
    @(negedge sysclk); poc = 1'b1;
    repeat (2) @(negedge sysclk);
    poc = 1'b0;
  endtask

  // Compare process: applies each clock edge to the model, then checks every output
  initial begin : compare
    forever begin
      @(posedge sysclk); #2;
      if (poc) begin
        q_instr.delete(); q_src.delete(); q_io.delete(); m_fifo.delete();
        m_cur = '0; m_src = '0; m_io = '0; m_resync = 1'b0; m_ovf = 1'b0; m_push = 1'b0;
        chk("rst_phase", phase, 0);
        chk("rst_in_sync", in_sync, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_io_valid", io_valid, 0);
        chk("rst_src_valid", src_valid, 0);
      end else begin
        if (trc_rd && m_fifo.size() != 0) void'(m_fifo.pop_front());
        if (m_push) begin
          if (m_fifo.size() < TD) m_fifo.push_back(m_push_val);
          else m_ovf = 1'b1;
        end
        m_push = 1'b0;
        if (instr_valid) begin
          if (q_instr.size() == 0) chk("instr_valid_unexpected", instr_valid, 0);
          else m_cur = q_instr.pop_front();
          m_push = 1'b1;
          m_push_val = {m_cur.addr, m_cur.opr, m_cur.opa};
        end
        if (io_valid) begin
          chk("io_with_instr", instr_valid, 1);
          if (q_io.size() == 0) chk("io_valid_unexpected", io_valid, 0);
          else m_io = q_io.pop_front();
        end
        if (src_valid) begin
          if (q_src.size() == 0) chk("src_valid_unexpected", src_valid, 0);
          else m_src = q_src.pop_front();
        end
      end
      chk("fetch_addr", fetch_addr, m_cur.addr);
      chk("opr", opr, m_cur.opr);
      chk("opa", opa, m_cur.opa);
      chk("rom_sel", rom_sel, m_cur.rom);
      chk("io_bank", io_bank, m_io);
      chk("src_bank", src_bank, m_src.bank);
      chk("src_addr", src_addr, m_src.addr);
      chk("resync_err", resync_err, m_resync);
      chk("trc_valid", trc_valid, m_fifo.size() != 0);
      chk("trc_data", trc_data, (m_fifo.size() != 0) ? m_fifo[0] : 20'h0);
      chk("trc_ovf", trc_ovf, m_ovf);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin : main
    int k;
    poc = 1'b1; clk1_pad = 1'b0; clk2_pad = 1'b0; sync_pad = 1'b0; cmrom_pad = 1'b0;
    cmram_pad = '0; data_pad = '0; trc_rd = 1'b0;
    repeat (3) @(negedge sysclk);
    poc = 1'b0;
    repeat (2) @(negedge sysclk);
    chk("idle_in_sync", in_sync, 0);
    lock();

    // Basic fetch 0x3A5, opcode D4, chip 3
    fetch({12'h3A5, 4'hD, 4'h4});
    @(negedge sysclk);
    chk("lit_fetch_addr", fetch_addr, 12'h3A5);
    chk("lit_opr", opr, 4'hD);
    chk("lit_opa", opa, 4'h4);
    chk("lit_rom_sel", rom_sel, 4'b1000);
    chk("lit_trc_head", trc_data, 20'h3A5D4);

    // Chip 0xF is beyond NUM_ROMS=4
    fetch({12'hF12, 4'h2, 4'h3});
    @(negedge sysclk);
    chk("lit_rom_sel_none", rom_sel, 4'b0000);
    chk("lit_fetch_addr_f", fetch_addr, 12'hF12);

    // SRC via cmram2
    cyc(12'h010, 4'h2, 4'h1, 1'b1, '0, 1'b0, 4'b0100, 1'b0, 4'h9, 4'h6);
    @(negedge sysclk);
    chk("lit_src_bank", src_bank, 3'd2);
    chk("lit_src_addr", src_addr, 8'h96);

    // I/O with cmram1 and cmram3 in M2
    cyc(12'h123, 4'hE, 4'h0, 1'b1, 4'b1010, 1'b0, '0, 1'b0, 4'h0, 4'h0);
    @(negedge sysclk);
    chk("lit_io_bank", io_bank, 3'd1);

    // CM-ROM only in M2 and X2
    cyc(12'h200, 4'hE, 4'h1, 1'b1, '0, 1'b1, '0, 1'b1, 4'h5, 4'hC);
    @(negedge sysclk);
    chk("lit_io_bank_rom", io_bank, 3'd4);
    chk("lit_src_bank_rom", src_bank, 3'd4);
    chk("lit_src_addr_rom", src_addr, 8'h5C);

    // SYNC at M1 aborts the cycle; the following cycle is captured normally
    sub(4'h1, 1'b0, 1'b0, '0, 3'd1);
    sub(4'h2, 1'b0, 1'b0, '0, 3'd2);
    sub(4'h0, 1'b0, 1'b1, '0, 3'd3);
    sub(4'h7, 1'b1, 1'b0, '0, 3'd0);
    m_resync = 1'b1;
    fetch({12'h456, 4'h8, 4'h9});
    @(negedge sysclk);
    chk("lit_resync_err", resync_err, 1);
    chk("lit_fetch_after_resync", fetch_addr, 12'h456);

    // 17 fetches with no reads: 16 kept, 17th dropped
    do_reset();
    lock();
    for (int i = 0; i < 17; i++) fetch(entry(i));
    @(negedge sysclk);
    chk("lit_trc_ovf", trc_ovf, 1);
    chk("lit_trc_head_ovf", trc_data, 20'h1000F);
    for (int i = 0; i < 18; i++) begin
      @(negedge sysclk);
      trc_rd = 1'b1;
      if (i < 16) chk("lit_drain", trc_data, entry(i));
      else chk("lit_drain_empty", trc_valid, 0);
    end
    @(negedge sysclk);
    trc_rd = 1'b0;

    // Full FIFO with push and pop in the same cycle: no overflow
    do_reset();
    lock();
    for (int i = 0; i < 16; i++) fetch(entry(i));
    fork
      fetch(entry(16));
      begin
        k = 0;
        while (instr_valid !== 1'b1 && k < 64) begin
          @(posedge sysclk); #2;
          k++;
        end
        if (k >= 64) chk("wait_instr_valid", instr_valid, 1);
        else begin
          @(negedge sysclk); trc_rd = 1'b1;
          @(negedge sysclk); trc_rd = 1'b0;
        end
      end
    join
    @(negedge sysclk);
    chk("lit_ovf_push_pop", trc_ovf, 0);
    chk("lit_head_push_pop", trc_data, entry(1));

    // poc in the middle of M1
    do_reset();
    lock();
    sub(4'h7, 1'b0, 1'b0, '0, 3'd1);
    sub(4'h7, 1'b0, 1'b0, '0, 3'd2);
    sub(4'h1, 1'b0, 1'b1, '0, 3'd3);
    @(negedge sysclk); data_pad = 4'hA; cmrom_pad = 1'b0; clk1_pad = 1'b1;
    @(negedge sysclk); clk1_pad = 1'b0; poc = 1'b1;
    repeat (2) @(negedge sysclk);
    poc = 1'b0;
    @(negedge sysclk);
    chk("lit_poc_phase", phase, 0);
    chk("lit_poc_in_sync", in_sync, 0);
    chk("lit_poc_fetch_addr", fetch_addr, 0);
    chk("lit_poc_trc_valid", trc_valid, 0);
    lock();
    fetch({12'hABC, 4'h5, 4'h6});
    @(negedge sysclk);
    chk("lit_after_poc_fetch", fetch_addr, 12'hABC);
    chk("lit_after_poc_rom_sel", rom_sel, 4'b0000);
    chk("lit_after_poc_head", trc_data, 20'hABC56);

    repeat (4) @(negedge sysclk);
    chk("pending_instr", q_instr.size(), 0);
    chk("pending_io", q_io.size(), 0);
    chk("pending_src", q_src.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
